// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// The decode stage uses the slave modport; the fetch/execute environment uses master.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_rd_addr;
  logic            ex_is_load;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rd_addr, ex_is_load, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rd_addr, ex_is_load, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: ID slot, register-file read, immediate decode, load-use bubble, flush.
// Define WB_BYPASS_EN to let same-cycle writeback data override register-file read data.
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter int          AW        = 5,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  decode_stage_if.slave   bus,
  output logic            rf_rd_en1,
  output logic            rf_rd_en2,
  output logic [AW-1:0]   rf_rd_addr1,
  output logic [AW-1:0]   rf_rd_addr2,
  input  logic [XLEN-1:0] rf_rd_data1,
  input  logic [XLEN-1:0] rf_rd_data2,
  input  logic            wb_wr_en,
  input  logic [AW-1:0]   wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic            is_load;
    logic            illegal;
  } ex_slot_t;

  localparam ex_slot_t EX_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR,
                                     rs1_data: '0, rs2_data: '0, imm: '0,
                                     rd: '0, is_load: 1'b0, illegal: 1'b0};

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  ex_slot_t        ex_q;
  ex_slot_t        ex_d;

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1, rs2, rd;
  logic            legal, uses_rs1, uses_rs2, is_load, no_wb;
  imm_fmt_e        imm_fmt;
  logic [31:12]    sign;
  logic [31:0]     imm32;
  logic [XLEN-1:0] op1, op2;
  logic            hazard, ex_free, id_adv, if_ready, accept;

  assign opcode = id_instr[6:0];
  assign rs1    = AW'(id_instr[19:15]);
  assign rs2    = AW'(id_instr[24:20]);
  assign rd     = AW'(id_instr[11:7]);
  assign sign   = {20{id_instr[31]}};

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    legal    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    imm_fmt  = IMM_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC: begin uses_rs1 = 1'b0; imm_fmt = IMM_U; end
      OP_JAL:           begin uses_rs1 = 1'b0; imm_fmt = IMM_J; end
      OP_JALR, OP_LOAD, OP_IMM: imm_fmt = IMM_I;
      OP_BRANCH:        begin uses_rs2 = 1'b1; imm_fmt = IMM_B; end
      OP_STORE:         begin uses_rs2 = 1'b1; imm_fmt = IMM_S; end
      OP_OP:            uses_rs2 = 1'b1;
      OP_MISC, OP_SYSTEM: ;
      default:          legal = 1'b0;
    endcase
  end

  assign is_load = (opcode == OP_LOAD);
  assign no_wb   = (opcode == OP_BRANCH) || (opcode == OP_STORE) || !legal;

  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      IMM_I: imm32 = {sign[31:12], id_instr[31:20]};
      IMM_S: imm32 = {sign[31:12], id_instr[31:25], id_instr[11:7]};
      IMM_B: imm32 = {sign[31:13], id_instr[31], id_instr[7], id_instr[30:25],
                      id_instr[11:8], 1'b0};
      IMM_U: imm32 = {id_instr[31:12], 12'b0};
      IMM_J: imm32 = {sign[31:21], id_instr[31], id_instr[19:12], id_instr[20],
                      id_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // x0 always reads as zero, whatever the register file returns.
  always_comb begin
`ifdef WB_BYPASS_EN
    op1 = (wb_wr_en && wb_wr_addr != '0 && wb_wr_addr == rs1) ? wb_wr_data : rf_rd_data1;
    op2 = (wb_wr_en && wb_wr_addr != '0 && wb_wr_addr == rs2) ? wb_wr_data : rf_rd_data2;
`else
    op1 = rf_rd_data1;
    op2 = rf_rd_data2;
`endif
    if (rs1 == '0) op1 = '0;
    if (rs2 == '0) op2 = '0;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_wr_en, wb_wr_addr, wb_wr_data};
`endif

  assign rf_rd_en1   = id_valid && uses_rs1;
  assign rf_rd_en2   = id_valid && uses_rs2;
  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

  // A load in EX whose result the ID instruction needs holds ID for one cycle.
  assign hazard  = ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                   ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));
  assign ex_free = !ex_q.valid || bus.ex_ready;
  assign id_adv  = id_valid && !hazard && ex_free;
  assign if_ready = !flush && (!id_valid || id_adv);
  assign accept   = bus.if_valid && if_ready;

  always_comb begin
    ex_d          = EX_BUBBLE;
    ex_d.valid    = 1'b1;
    ex_d.pc       = id_pc;
    ex_d.instr    = id_instr;
    ex_d.rs1_data = op1;
    ex_d.rs2_data = op2;
    ex_d.imm      = XLEN'($signed(imm32));
    ex_d.rd       = no_wb ? '0 : rd;
    ex_d.is_load  = is_load;
    ex_d.illegal  = !legal;
  end

  // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      ex_q     <= EX_BUBBLE;
    end else if (flush) begin
      id_valid <= 1'b0;
      ex_q     <= EX_BUBBLE;
    end else begin
      if (accept) begin
        id_valid <= 1'b1;
        id_instr <= bus.if_instr;
        id_pc    <= bus.if_pc;
      end else if (id_adv) begin
        id_valid <= 1'b0;
      end
      if (ex_free) ex_q <= id_adv ? ex_d : EX_BUBBLE;
    end
  end

  assign bus.if_ready    = if_ready;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_instr    = ex_q.instr;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rd_addr  = ex_q.rd;
  assign bus.ex_is_load  = ex_q.is_load;
  assign bus.ex_illegal  = ex_q.illegal;

endmodule
